// File: rtl/weight_loader.sv
// Weight memory write-side loader: takes a host byte stream over valid/ready and writes
// consecutive weight addresses starting at a programmed base, with a range check up front.
module weight_loader #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned LEN_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                error_q, error_d;
  logic                handshake;
  logic [ADDR_W:0]     end_addr;

  // One extra bit so a base near the top of the address space cannot wrap past the check.
  assign end_addr  = {1'b0, base_addr} + (ADDR_W+1)'(length);
  assign handshake = in_valid && (state_q == S_LOAD);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    error_d     = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          cnt_d   = '0;
          error_d = 1'b0;
          if (end_addr > (ADDR_W+1)'(MEM_DEPTH)) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (length == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (handshake) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + ADDR_W'(cnt_q);
          mem_wdata_d = in_data;
          cnt_d       = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign error     = error_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: vector table for plain loads, hand sequences for
// range error, reset abort and start-while-busy/done corners.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [12:0] base_addr;
  logic [5:0]  length;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done, error;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  weight_loader #(.ADDR_W(13), .DATA_W(8), .MEM_DEPTH(32), .LEN_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
  );

  // Expected output bundle: {we, addr, wdata, ready, busy, done, error}
  typedef struct {
    string       name;
    logic        rst, st, vld;
    logic [12:0] base;
    logic [5:0]  len;
    logic [7:0]  data;
    logic [25:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [25:0] E(input logic we, input logic [12:0] a, input logic [7:0] d,
                                    input logic rdy, input logic bsy, input logic dn, input logic err);
    return {we, a, d, rdy, bsy, dn, err};
  endfunction

  function automatic vec_t V(input string n, input logic r, input logic s, input logic [12:0] b,
                             input logic [5:0] l, input logic vl, input logic [7:0] dt,
                             input logic [25:0] ex);
    vec_t t;
    t.name = n; t.rst = r; t.st = s; t.base = b; t.len = l; t.vld = vl; t.data = dt; t.exp = ex;
    return t;
  endfunction

  task automatic drive(input logic r, input logic s, input logic [12:0] b, input logic [5:0] l,
                       input logic vl, input logic [7:0] dt);
    reset = r; start = s; base_addr = b; length = l; in_valid = vl; in_data = dt;
  endtask

  task automatic tick_check(input string n, input logic [25:0] ex);
    logic [25:0] act;
    @(posedge clk);
    #1;
    act = {mem_we, mem_addr, mem_wdata, in_ready, busy, done, error};
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got we=%b addr=%0d wdata=%h rdy=%b busy=%b done=%b err=%b, want we=%b addr=%0d wdata=%h rdy=%b busy=%b done=%b err=%b",
               n, act[25], act[24:12], act[11:4], act[3], act[2], act[1], act[0],
               ex[25], ex[24:12], ex[11:4], ex[3], ex[2], ex[1], ex[0]);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b1, 8'hFF);

    // 1: reset, valid ignored
    vq.push_back(V("t1_rst0", 1, 0, 0, 0, 1, 8'hFF, E(0, 0, 8'h00, 0, 0, 0, 0)));
    vq.push_back(V("t1_rst1", 1, 0, 0, 0, 1, 8'hFF, E(0, 0, 8'h00, 0, 0, 0, 0)));
    vq.push_back(V("t1_idle", 0, 0, 0, 0, 1, 8'hFF, E(0, 0, 8'h00, 0, 0, 0, 0)));
    // 2: back-to-back load base 4 len 4
    vq.push_back(V("t2_start", 0, 1, 4, 4, 0, 8'h00, E(0, 0, 8'h00, 1, 1, 0, 0)));
    vq.push_back(V("t2_b0",    0, 0, 0, 0, 1, 8'h11, E(1, 4, 8'h11, 1, 1, 0, 0)));
    vq.push_back(V("t2_b1",    0, 0, 0, 0, 1, 8'h22, E(1, 5, 8'h22, 1, 1, 0, 0)));
    vq.push_back(V("t2_b2",    0, 0, 0, 0, 1, 8'h33, E(1, 6, 8'h33, 1, 1, 0, 0)));
    vq.push_back(V("t2_b3",    0, 0, 0, 0, 1, 8'h44, E(1, 7, 8'h44, 0, 1, 1, 0)));
    vq.push_back(V("t2_idle",  0, 0, 0, 0, 0, 8'h00, E(0, 7, 8'h44, 0, 0, 0, 0)));
    // 3: valid pattern 1,0,0,1,1,0,1
    vq.push_back(V("t3_start", 0, 1, 4, 4, 0, 8'h00, E(0, 7, 8'h44, 1, 1, 0, 0)));
    vq.push_back(V("t3_v1",    0, 0, 0, 0, 1, 8'h55, E(1, 4, 8'h55, 1, 1, 0, 0)));
    vq.push_back(V("t3_v0a",   0, 0, 0, 0, 0, 8'hEE, E(0, 4, 8'h55, 1, 1, 0, 0)));
    vq.push_back(V("t3_v0b",   0, 0, 0, 0, 0, 8'hEE, E(0, 4, 8'h55, 1, 1, 0, 0)));
    vq.push_back(V("t3_v1b",   0, 0, 0, 0, 1, 8'h66, E(1, 5, 8'h66, 1, 1, 0, 0)));
    vq.push_back(V("t3_v1c",   0, 0, 0, 0, 1, 8'h77, E(1, 6, 8'h77, 1, 1, 0, 0)));
    vq.push_back(V("t3_v0c",   0, 0, 0, 0, 0, 8'hEE, E(0, 6, 8'h77, 1, 1, 0, 0)));
    vq.push_back(V("t3_v1d",   0, 0, 0, 0, 1, 8'h88, E(1, 7, 8'h88, 0, 1, 1, 0)));
    vq.push_back(V("t3_idle",  0, 0, 0, 0, 0, 8'h00, E(0, 7, 8'h88, 0, 0, 0, 0)));
    // 4: zero length
    vq.push_back(V("t4_len0",  0, 1, 0, 0, 1, 8'h99, E(0, 7, 8'h88, 0, 1, 1, 0)));
    vq.push_back(V("t4_idle",  0, 0, 0, 0, 1, 8'h99, E(0, 7, 8'h88, 0, 0, 0, 0)));

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].st, vq[i].base, vq[i].len, vq[i].vld, vq[i].data);
      tick_check(vq[i].name, vq[i].exp);
    end

    // 5: out-of-range load, then exact fit at the top of memory
    drive(0, 1, 30, 4, 0, 8'h00); tick_check("t5_err",    E(0, 7, 8'h88, 0, 1, 1, 1));
    drive(0, 0, 0, 0, 0, 8'h00);  tick_check("t5_sticky", E(0, 7, 8'h88, 0, 0, 0, 1));
    drive(0, 1, 28, 4, 0, 8'h00); tick_check("t5_clr",    E(0, 7, 8'h88, 1, 1, 0, 0));
    for (int unsigned k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 1, 8'hC1 + 8'(k));
      tick_check("t5_wr", E(1, 13'(28 + k), 8'hC1 + 8'(k), k != 3, 1, k == 3, 0));
    end
    drive(0, 0, 0, 0, 0, 8'h00);  tick_check("t5_idle",   E(0, 31, 8'hC4, 0, 0, 0, 0));

    // 6: reset mid-load, restart, start ignored in LOAD and DONE
    drive(0, 1, 0, 8, 0, 8'h00);  tick_check("t6_start",  E(0, 31, 8'hC4, 1, 1, 0, 0));
    for (int unsigned k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 8'hD0 + 8'(k));
      tick_check("t6_wr", E(1, 13'(k), 8'hD0 + 8'(k), 1, 1, 0, 0));
    end
    drive(1, 0, 0, 0, 1, 8'hFF);  tick_check("t6_rst",    E(0, 0, 8'h00, 0, 0, 0, 0));
    drive(0, 1, 8, 2, 0, 8'h00);  tick_check("t6_restart",E(0, 0, 8'h00, 1, 1, 0, 0));
    drive(0, 1, 3, 5, 1, 8'hE0);  tick_check("t6_stload", E(1, 8, 8'hE0, 1, 1, 0, 0));
    drive(0, 0, 0, 0, 1, 8'hE1);  tick_check("t6_last",   E(1, 9, 8'hE1, 0, 1, 1, 0));
    drive(0, 1, 20, 1, 0, 8'h00); tick_check("t6_stdone", E(0, 9, 8'hE1, 0, 0, 0, 0));
    drive(0, 1, 20, 1, 0, 8'h00); tick_check("t6_stidle", E(0, 9, 8'hE1, 1, 1, 0, 0));
    drive(0, 0, 0, 0, 1, 8'h5A);  tick_check("t6_one",    E(1, 20, 8'h5A, 0, 1, 1, 0));
    drive(0, 0, 0, 0, 0, 8'h00);  tick_check("t6_idle",   E(0, 20, 8'h5A, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
